// File: rtl/stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stage_if: RISC-V fetch stage, builds 32-bit words from four byte reads.    |
// | Optional ICACHE_EN adds a 16-entry direct-mapped instruction cache. rev 1.0|
// +----------------------------------------------------------------------------+
module stage_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [7:0]  mem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  localparam logic [2:0] S_F0  = 3'd0;
  localparam logic [2:0] S_F1  = 3'd1;
  localparam logic [2:0] S_F2  = 3'd2;
  localparam logic [2:0] S_F3  = 3'd3;
  localparam logic [2:0] S_OUT = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [23:0] r_inst;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_word;
  logic [31:0] w_hit_word;
  logic        w_hit;
  logic        w_take;

  assign w_tgt  = branch_target_i & ~32'h3;
  assign w_word = {mem_data_i, r_inst};
  assign w_take = (r_state == S_OUT) && !stall_i;

  // PC of the fetch that starts next edge; also the cache lookup address
  always_comb begin
    w_pc_nxt = r_pc;
    if (branch_flag_i) begin
      w_pc_nxt = w_tgt;
    end else if (w_take) begin
      w_pc_nxt = r_pc + 32'd4;
    end
  end

`ifdef ICACHE_EN
  logic [25:0] r_tag  [16];
  logic [31:0] r_data [16];
  logic [15:0] r_vld;
  logic [3:0]  w_idx;

  assign w_idx      = w_pc_nxt[5:2];
  assign w_hit      = r_vld[w_idx] && (r_tag[w_idx] == w_pc_nxt[31:6]);
  assign w_hit_word = r_data[w_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else if (!branch_flag_i && (r_state == S_F3) && mem_req_o && mem_valid_i) begin
      r_vld[r_pc[5:2]]  <= 1'b1;
      r_tag[r_pc[5:2]]  <= r_pc[31:6];
      r_data[r_pc[5:2]] <= w_word;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_F0;
      r_pc         <= '0;
      r_inst       <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      inst_valid_o <= 1'b0;
      pc_o         <= '0;
      inst_o       <= '0;
    end else if (branch_flag_i || w_take) begin
      // Redirect or consume: start a fresh word, skipping the request on a cache hit
      r_state      <= S_F0;
      r_pc         <= w_pc_nxt;
      inst_valid_o <= 1'b0;
      mem_req_o    <= !w_hit;
      mem_addr_o   <= w_pc_nxt;
    end else if (r_state != S_OUT) begin
      if (!mem_req_o) begin
        if (w_hit) begin
          r_state      <= S_OUT;
          inst_valid_o <= 1'b1;
          pc_o         <= r_pc;
          inst_o       <= w_hit_word;
        end else begin
          mem_req_o  <= 1'b1;
          mem_addr_o <= r_pc;
        end
      end else if (mem_valid_i) begin
        if (r_state == S_F3) begin
          r_state      <= S_OUT;
          mem_req_o    <= 1'b0;
          inst_valid_o <= 1'b1;
          pc_o         <= r_pc;
          inst_o       <= w_word;
        end else begin
          case (r_state[1:0])
            2'd0:    r_inst[7:0]   <= mem_data_i;
            2'd1:    r_inst[15:8]  <= mem_data_i;
            default: r_inst[23:16] <= mem_data_i;
          endcase
          r_state    <= r_state + 3'd1;
          mem_addr_o <= r_pc + {29'd0, r_state + 3'd1};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_if.sv
`default_nettype none
// tb_stage_if: directed and randomized checks of stage_if against a
// word-level fetch model driven by a byte-wide memory responder.
module tb_stage_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [7:0]  mem_data_i;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  always #5 clk = ~clk;

  stage_if dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_valid_i     (mem_valid_i),
    .mem_data_i      (mem_data_i),
    .inst_valid_o    (inst_valid_o),
    .pc_o            (pc_o),
    .inst_o          (inst_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
    h = a * 32'h9E3779B1;
    return h[31:24] ^ a[7:0];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  // Word-level model: current fetch PC, bytes received so far, offer flag,
  // the quiet cycle after reset, and a cache remembered as the PC held per index.
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_offer;
  bit          m_idle;
  bit          chk_en = 1'b0;
  logic [31:0] c_pc [16];
  bit          c_v  [16];

  function automatic bit m_hit();
`ifdef ICACHE_EN
    return !m_offer && !m_idle && (m_cnt == 0) && c_v[m_pc[5:2]] && (c_pc[m_pc[5:2]] == m_pc);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc    = '0;
      m_cnt   = 0;
      m_offer = 1'b0;
      m_idle  = 1'b1;
      for (int i = 0; i < 16; i++) c_v[i] = 1'b0;
    end else if (branch_flag_i) begin
      m_pc    = branch_target_i & ~32'h3;
      m_cnt   = 0;
      m_offer = 1'b0;
      m_idle  = 1'b0;
    end else if (m_offer) begin
      if (!stall_i) begin
        m_pc    = m_pc + 32'd4;
        m_cnt   = 0;
        m_offer = 1'b0;
      end
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_hit()) begin
      m_offer = 1'b1;
    end else if (mem_valid_i) begin
      m_cnt++;
      if (m_cnt == 4) begin
        m_offer          = 1'b1;
        c_v[m_pc[5:2]]   = 1'b1;
        c_pc[m_pc[5:2]]  = m_pc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_req;
      exp_req = !m_offer && !m_idle && !m_hit();
      chk("inst_valid_o", {31'd0, inst_valid_o}, {31'd0, m_offer});
      chk("mem_req_o", {31'd0, mem_req_o}, {31'd0, exp_req});
      if (exp_req) chk("mem_addr_o", mem_addr_o, m_pc + 32'(m_cnt));
      if (m_offer) begin
        chk("pc_o", pc_o, m_pc);
        chk("inst_o", inst_o, mem_word(m_pc));
      end
    end
  end

  // Memory responder state: cycles the current request has been visible
  int          age;
  bit          rand_mode;
  bit          p_req, p_valid, p_branch, p_rst;
  logic [31:0] p_addr;

  task automatic tick();
    p_req    = mem_req_o;
    p_addr   = mem_addr_o;
    p_valid  = mem_valid_i;
    p_branch = branch_flag_i;
    p_rst    = rst;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    branch_flag_i = 1'b0;
    mem_valid_i   = 1'b0;
    mem_data_i    = 8'($urandom);
    if (!mem_req_o || !p_req || p_valid || p_branch || p_rst || (mem_addr_o != p_addr)) age = 0;
    else age++;
    if (mem_req_o && (age >= 1) && (!rand_mode || ($urandom_range(0, 2) != 0))) begin
      mem_valid_i = 1'b1;
      mem_data_i  = mem_byte(mem_addr_o);
    end else if (rand_mode && inst_valid_o && ($urandom_range(0, 3) == 0)) begin
      mem_valid_i = 1'b1;
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!inst_valid_o && (n < budget)) begin
      tick();
      n++;
    end
    chk("wait_valid", {31'd0, inst_valid_o}, 32'd1);
  endtask

  task automatic wait_addr(input logic [31:0] a, input int budget);
    int n = 0;
    while (!(mem_req_o && (mem_addr_o == a)) && (n < budget)) begin
      tick();
      n++;
    end
    chk("wait_addr", mem_addr_o, a);
  endtask

  task automatic wait_resp(input logic [31:0] a, input int budget);
    int n = 0;
    while (!(mem_valid_i && (mem_addr_o == a)) && (n < budget)) begin
      tick();
      n++;
    end
    chk("wait_resp", {31'd0, mem_valid_i}, 32'd1);
  endtask

  initial begin
    rst             = 1'b1;
    stall_i         = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = '0;
    mem_valid_i     = 1'b0;
    mem_data_i      = '0;
    rand_mode       = 1'b0;
    age             = 0;
    tick();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    chk("rst mem_req_o", {31'd0, mem_req_o}, 32'd0);
    chk("rst mem_addr_o", mem_addr_o, 32'd0);
    chk("rst inst_valid_o", {31'd0, inst_valid_o}, 32'd0);
    chk("rst pc_o", pc_o, 32'd0);
    chk("rst inst_o", inst_o, 32'd0);

    // First fetch with a one-cycle responder
    for (int c = 1; c <= 10; c++) begin
      tick();
      case (c)
        1:  chk("first addr0", mem_addr_o, 32'h0);
        3:  chk("first addr1", mem_addr_o, 32'h1);
        5:  chk("first addr2", mem_addr_o, 32'h2);
        7:  chk("first addr3", mem_addr_o, 32'h3);
        8:  chk("first valid c8", {31'd0, inst_valid_o}, 32'd0);
        9: begin
          chk("first valid c9", {31'd0, inst_valid_o}, 32'd1);
          chk("first pc_o", pc_o, 32'h0);
          chk("first inst_o", inst_o, 32'h00000013);
        end
        10: chk("next addr", mem_addr_o, 32'h4);
        default: ;
      endcase
    end

    // Hold under stall
    stall_i = 1'b1;
    wait_valid(40);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall valid", {31'd0, inst_valid_o}, 32'd1);
      chk("stall req", {31'd0, mem_req_o}, 32'd0);
      chk("stall pc_o", pc_o, 32'h4);
      chk("stall inst_o", inst_o, mem_word(32'h4));
    end
    stall_i = 1'b0;
    tick();
    chk("after stall addr", mem_addr_o, 32'h8);

    // Redirect during byte 2
    wait_addr(32'hA, 40);
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h00000107;
    tick();
    chk("redirect addr", mem_addr_o, 32'h104);
    wait_valid(40);
    chk("redirect pc_o", pc_o, 32'h104);

    // Redirect coinciding with the last byte
    wait_resp(32'h10B, 40);
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h00000200;
    tick();
    chk("drop valid", {31'd0, inst_valid_o}, 32'd0);
    chk("drop addr", mem_addr_o, 32'h200);
    tick();
    chk("drop valid2", {31'd0, inst_valid_o}, 32'd0);
    wait_valid(40);
    chk("target pc_o", pc_o, 32'h200);

    // Reset mid-fetch
    wait_addr(32'h205, 40);
    rst = 1'b1;
    tick();
    chk("midrst req", {31'd0, mem_req_o}, 32'd0);
    chk("midrst addr", mem_addr_o, 32'd0);
    chk("midrst valid", {31'd0, inst_valid_o}, 32'd0);
    chk("midrst pc_o", pc_o, 32'd0);
    chk("midrst inst_o", inst_o, 32'd0);
    tick();
    chk("restart addr", mem_addr_o, 32'h0);

    // PC wrap at the top of the address space
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hFFFFFFFE;
    tick();
    chk("wrap addr", mem_addr_o, 32'hFFFFFFFC);
    wait_valid(40);
    chk("wrap pc_o", pc_o, 32'hFFFFFFFC);
    tick();
    chk("wrapped addr", mem_addr_o, 32'h0);

`ifdef ICACHE_EN
    wait_valid(40);
    chk("cache fill pc_o", pc_o, 32'h0);
    tick();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0;
    tick();
    chk("cache no req", {31'd0, mem_req_o}, 32'd0);
    tick();
    chk("cache valid", {31'd0, inst_valid_o}, 32'd1);
    chk("cache inst_o", inst_o, 32'h00000013);
`endif

    // Randomized traffic
    rand_mode = 1'b1;
    repeat (3000) begin
      tick();
      stall_i = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 99) < 4) begin
        branch_flag_i   = 1'b1;
        branch_target_i = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 127);
      end
      if ($urandom_range(0, 999) < 5) rst = 1'b1;
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage of the RISC-V pipeline and the producer side of the decode stage's `pc`/`inst` input. It fetches 32-bit instructions over the byte-wide memory port, assembling four little-endian byte reads per instruction. It presents each instruction with its PC and a valid flag to `stage_id`, holds it while decode stalls, and redirects immediately on a taken branch or jump.

## Interface
Parameters: none (widths come from the shared defines: `InstAddrBus` 32, `InstBus` 32).

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- stall_i  in  1  decode back-pressure; an offered instruction is not consumed this cycle
- branch_flag_i  in  1  taken branch/jump redirect request
- branch_target_i  in  32  redirect PC; bits [1:0] ignored, forced to 0
- mem_req_o  out  1  byte read request to memory arbiter
- mem_addr_o  out  32  byte address of current request
- mem_valid_i  in  1  arbiter returns the byte for the current `mem_addr_o` this cycle
- mem_data_i  in  8  returned byte, sampled only when `mem_valid_i`=1
- inst_valid_o  out  1  `pc_o`/`inst_o` hold a valid instruction for decode
- pc_o  out  32  address of offered instruction
- inst_o  out  32  offered instruction word

## Operation
- State machine: F0, F1, F2, F3 (fetch byte k at pc+k), OUT (instruction offered).
- Reset: pc=0, state F0, inst_valid_o=0, pc_o=0, inst_o=0, mem_req_o=0, mem_addr_o=0. Requests begin the cycle after `rst` deasserts.
- Fk: mem_req_o=1, mem_addr_o=pc+k, held stable until `mem_valid_i`. On `mem_valid_i`:
  - mem_data_i is stored in inst[8k+7:8k].
  - Fk advances to Fk+1; F3 advances to OUT.
  - mem_addr_o changes the following cycle.
- OUT: mem_req_o=0, inst_valid_o=1, pc_o=pc, inst_o=assembled word.
  - stall_i=1: hold all outputs unchanged.
  - stall_i=0: instruction consumed; pc←pc+4 (32-bit wrap, 0xFFFFFFFC→0), state F0, inst_valid_o=0 the next cycle.
- Redirect has priority over everything except rst. branch_flag_i=1 in any state:
  - pc←{branch_target_i[31:2],2'b00}, state F0, inst_valid_o=0 next cycle, partial word discarded.
  - A byte returned by mem_valid_i in the same cycle is dropped.
  - An offered instruction in the same cycle is dropped, even when stall_i=0.
- rst=1 in any state, including mid-fetch, returns to reset values next edge; an in-flight request is abandoned.
- mem_valid_i while in OUT is ignored.

## Timing
- Responder answers exactly one cycle after the address appears: each byte costs 2 cycles, so one instruction takes 8 cycles in F0–F3 and inst_valid_o rises on cycle 9 after reset release.
- Uncached steady-state throughput is 1 instruction per 9 cycles.
- mem_valid_i is legal no earlier than the cycle after the address first appears. Slower responders stretch the Fk dwell without limit.
- Redirect latency: request for the target byte 0 appears the cycle after branch_flag_i.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `ICACHE_EN` defined: 16-entry direct-mapped instruction cache.
  - Index pc[5:2], tag pc[31:6], per-entry valid bits cleared on rst.
  - In F0, on a hit: no memory request (mem_req_o stays 0) and OUT the next cycle, giving 1 instruction per 2 cycles.
  - On a miss: normal F0–F3 fetch, and the entry is filled when F3 completes.
  - A fetch aborted by a redirect does not fill.
- `ICACHE_EN` undefined: no cache storage; every instruction goes through F0–F3.

## Test plan
- Reset then memory bytes 13 00 00 00 at 0x0–0x3, 1-cycle responder, stall_i=0 -> mem_addr_o 0,1,2,3 in order; inst_valid_o=1 on cycle 9 with pc_o=0, inst_o=0x00000013; next request at address 4.
- Instruction offered with stall_i=1 for 5 cycles -> pc_o/inst_o/inst_valid_o constant and mem_req_o=0; stall_i=0 -> pc advances by exactly 4.
- branch_flag_i=1 with target 0x00000107 during F2 -> partial word discarded, next mem_addr_o=0x00000104, later pc_o=0x00000104.
- branch_flag_i=1 in the same cycle as mem_valid_i of byte 3 -> no instruction offered; fetch restarts at the target.
- rst asserted during F1 -> all outputs return to reset values next edge; fetch restarts at 0.
- With `ICACHE_EN`, jump back to 0x0 after the first fetch -> no mem_req_o; inst_valid_o the cycle after F0; inst_o=0x00000013.
